// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one data-memory port between instruction fetch (IF) and
//             load/store (LS); one access at a time, LS-priority with an
//             IF starvation guard.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction fetch
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_gnt,
    output logic                  o_if_rvalid,
    output logic [DATA_W-1:0]     o_if_rdata,
    // load/store
    input  logic                  i_ls_req,
    input  logic                  i_ls_wen,
    input  logic [ADDR_W-1:0]     i_ls_addr,
    input  logic [DATA_W-1:0]     i_ls_wdata,
    input  logic [DATA_W/8-1:0]   i_ls_wmask,
    output logic                  o_ls_gnt,
    output logic                  o_ls_rvalid,
    output logic [DATA_W-1:0]     o_ls_rdata,
    // memory
    output logic                  o_mem_ren,
    output logic                  o_mem_wen,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    output logic [DATA_W/8-1:0]   o_mem_wmask,
    input  logic [DATA_W-1:0]     i_mem_rdata
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MEM_LAT + 1);
    localparam int SC_W   = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] c_wait_init  = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
    localparam logic [SC_W-1:0]  c_starve_max = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SC_W-1:0]     r_starve;
    logic                r_owner_ls;
    logic                r_wen;
    logic                r_mem_ren;
    logic                r_mem_wen;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [MASK_W-1:0]   r_mem_wmask;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_ls_rdata;

    logic                w_idle;
    logic                w_starved;
    logic                w_gnt_ls;
    logic                w_gnt_if;
    logic                w_resp;
    logic [DATA_W-1:0]   w_resp_data;

    // Grants are combinational in IDLE and suppressed while reset is held.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_starved   = (r_starve == c_starve_max);
    assign w_gnt_ls    = w_idle && i_ls_req && !(i_if_req && w_starved);
    assign w_gnt_if    = w_idle && i_if_req && !w_gnt_ls;
    assign w_resp      = (r_state == S_RESP) && !rst;
    assign w_resp_data = r_wen ? '0 : i_mem_rdata;

    assign o_if_gnt    = w_gnt_if;
    assign o_ls_gnt    = w_gnt_ls;
    assign o_if_rvalid = w_resp && !r_owner_ls;
    assign o_ls_rvalid = w_resp && r_owner_ls;
    assign o_if_rdata  = rst ? '0 : (o_if_rvalid ? w_resp_data : r_if_rdata);
    assign o_ls_rdata  = rst ? '0 : (o_ls_rvalid ? w_resp_data : r_ls_rdata);
    assign o_mem_ren   = r_mem_ren && !rst;
    assign o_mem_wen   = r_mem_wen && !rst;
    assign o_mem_addr  = rst ? '0 : r_mem_addr;
    assign o_mem_wdata = rst ? '0 : r_mem_wdata;
    assign o_mem_wmask = rst ? '0 : r_mem_wmask;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_starve    <= '0;
            r_owner_ls  <= 1'b0;
            r_wen       <= 1'b0;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;

            // Consecutive LS wins while IF waits; any IF-idle cycle resets it.
            if (!i_if_req || w_gnt_if) begin
                r_starve <= '0;
            end else if (w_gnt_ls && (r_starve != c_starve_max)) begin
                r_starve <= r_starve + SC_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_gnt_ls || w_gnt_if) begin
                        r_owner_ls  <= w_gnt_ls;
                        r_wen       <= w_gnt_ls && i_ls_wen;
                        r_mem_ren   <= !(w_gnt_ls && i_ls_wen);
                        r_mem_wen   <= w_gnt_ls && i_ls_wen;
                        r_mem_addr  <= w_gnt_ls ? i_ls_addr  : i_if_addr;
                        r_mem_wdata <= w_gnt_ls ? i_ls_wdata : '0;
                        r_mem_wmask <= w_gnt_ls ? i_ls_wmask : '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (MEM_LAT == 1) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= c_wait_init;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt <= c_cnt_one) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                S_RESP: begin
                    if (r_owner_ls) begin
                        r_ls_rdata <= w_resp_data;
                    end else begin
                        r_if_rdata <= w_resp_data;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
